// File: rtl/lenet_input_reader_pkg.sv
// Shared constants, state encoding and pad-geometry helper for the LeNet input reader.
package lenet_input_reader_pkg;

  localparam int         CNN_INPUT_WIDTH_DEF  = 28;
  localparam int         CNN_INPUT_HEIGHT_DEF = 28;
  localparam int         CNN_INPUT_PAD_DEF    = 2;
  localparam int         REAL_W               = CNN_INPUT_WIDTH_DEF + 2 * CNN_INPUT_PAD_DEF;
  localparam int         REAL_H               = CNN_INPUT_HEIGHT_DEF + 2 * CNN_INPUT_PAD_DEF;
  localparam logic [7:0] PAD_VALUE_DEF        = 8'h00;
  localparam int         ADDR_W_DEF           = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READ    = 2'd2,
    DONE    = 2'd3
  } rd_state_t;

  // True when (r, c) lies in the zero border around the active image.
  function automatic logic is_pad(
    input int r,
    input int c,
    input int w   = CNN_INPUT_WIDTH_DEF,
    input int h   = CNN_INPUT_HEIGHT_DEF,
    input int pad = CNN_INPUT_PAD_DEF
  );
    return (r < pad) || (r >= pad + h) || (c < pad) || (c >= pad + w);
  endfunction

endpackage

// File: rtl/lenet_input_reader_if.sv
// Buffer read port and pixel stream between the input reader and its neighbours.
interface lenet_input_reader_if
  import lenet_input_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [7:0]        rd_data;
  logic [7:0]        pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_last;

  modport master (
    output rd_addr,
    output rd_en,
    input  rd_data,
    output pix_data,
    output pix_valid,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  rd_addr,
    input  rd_en,
    output rd_data,
    input  pix_data,
    input  pix_valid,
    input  pix_last,
    output pix_ready
  );

endinterface

// File: rtl/lenet_input_reader_skid.sv
// Two-entry FIFO holding pixel data plus its last flag; head drives the output stream.
module lenet_rd_skid
  import lenet_input_reader_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk24,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic [1:0]        o_count
);

  logic [DATA_W:0] r_mem [2];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;
  logic            w_pop;
  logic            w_push;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is legal when popping.
  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {i_last, i_data};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid           = (r_count != 2'd0);
  assign {o_last, o_data}  = r_mem[r_rd_ptr];
  assign o_count           = r_count;

endmodule

// File: rtl/lenet_input_reader.sv
// Reads the padded LeNet input buffer in raster order and streams pixels downstream,
// synthesising the pad border locally and requesting a new capture between frames.
module lenet_input_reader
  import lenet_input_reader_pkg::*;
#(
  parameter int         CNN_INPUT_WIDTH  = CNN_INPUT_WIDTH_DEF,
  parameter int         CNN_INPUT_HEIGHT = CNN_INPUT_HEIGHT_DEF,
  parameter int         CNN_INPUT_PAD    = CNN_INPUT_PAD_DEF,
  parameter logic [7:0] PAD_VALUE        = PAD_VALUE_DEF,
  parameter int         ADDR_W           = ADDR_W_DEF
) (
  input  logic                 clk24,
  input  logic                 rst_n,
  input  logic                 i_enable,
  input  logic                 i_lenet_data_ready,
  output logic                 o_lenet_doing_signal,
  output logic                 o_frame_done,
  output logic                 o_busy,
  lenet_input_reader_if.master bus
);

  localparam int TOT_W = CNN_INPUT_WIDTH + 2 * CNN_INPUT_PAD;
  localparam int TOT_H = CNN_INPUT_HEIGHT + 2 * CNN_INPUT_PAD;
  localparam int N_PIX = TOT_W * TOT_H;
  localparam int IDX_W = ADDR_W + 1;
  localparam int RC_W  = $clog2(((TOT_W > TOT_H) ? TOT_W : TOT_H) + 1);

  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(N_PIX);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PIX - 1);
  localparam logic [RC_W-1:0]  COL_LAST = RC_W'(TOT_W - 1);

  rd_state_t r_state;
  rd_state_t w_next_state;

  logic [RC_W-1:0]  r_row;
  logic [RC_W-1:0]  r_col;
  logic [IDX_W-1:0] r_idx;

  // One-cycle issue pipeline shared by pad and read slots keeps pixels in index order.
  logic r_pend;
  logic r_pend_pad;
  logic r_pend_last;

  logic       w_pad;
  logic       w_last_idx;
  logic       w_issue;
  logic       w_rd_en;
  logic [2:0] w_slots;
  logic [1:0] w_count;
  logic       w_valid;
  logic       w_pop;
  logic       w_head_last;
  logic [7:0] w_head_data;
  logic [7:0] w_push_data;

  assign w_pad      = is_pad(int'(r_row), int'(r_col), CNN_INPUT_WIDTH, CNN_INPUT_HEIGHT,
                             CNN_INPUT_PAD);
  assign w_last_idx = (r_idx == IDX_LAST);

  // Slots committed after this cycle: stored entries plus the one in flight, less a pop.
  assign w_slots = {1'b0, w_count} + {2'b00, r_pend} - {2'b00, w_pop};
  assign w_issue = (r_state == READ) && (r_idx != IDX_END) && (w_slots < 3'd2);
  assign w_rd_en = w_issue && !w_pad;

  assign bus.rd_en   = w_rd_en;
  assign bus.rd_addr = w_rd_en ? r_idx[ADDR_W-1:0] : '0;

  assign w_pop       = w_valid && bus.pix_ready;
  assign w_push_data = r_pend_pad ? PAD_VALUE : bus.rd_data;

  lenet_rd_skid #(
    .DATA_W (8)
  ) u_skid (
    .clk24   (clk24),
    .rst_n   (rst_n),
    .i_push  (r_pend),
    .i_data  (w_push_data),
    .i_last  (r_pend_last),
    .i_pop   (w_pop),
    .o_valid (w_valid),
    .o_data  (w_head_data),
    .o_last  (w_head_last),
    .o_count (w_count)
  );

  assign bus.pix_valid = w_valid;
  assign bus.pix_data  = w_head_data;
  assign bus.pix_last  = w_head_last;

  assign o_lenet_doing_signal = (r_state == CAPTURE);
  assign o_frame_done         = (r_state == DONE);
  assign o_busy               = (r_state != IDLE);

  // State register.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: disable beats a coincident data_ready in CAPTURE; READ always finishes.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_enable) begin
          w_next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!i_enable) begin
          w_next_state = IDLE;
        end else if (i_lenet_data_ready) begin
          w_next_state = READ;
        end
      end
      READ: begin
        if (w_pop && w_head_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = i_enable ? CAPTURE : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Raster position and linear index; cleared once per frame in DONE.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
      r_idx <= '0;
    end else if (r_state == DONE) begin
      r_row <= '0;
      r_col <= '0;
      r_idx <= '0;
    end else if (w_issue) begin
      r_idx <= r_idx + 1'b1;
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Issued slot waits one cycle so read data and pad values enter the FIFO together in order.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= 1'b0;
      r_pend_pad  <= 1'b0;
      r_pend_last <= 1'b0;
    end else begin
      r_pend      <= w_issue;
      r_pend_pad  <= w_pad;
      r_pend_last <= w_last_idx;
    end
  end

endmodule

// File: tb/tb_lenet_input_reader.sv
// Directed bench for the LeNet input reader with a pixel scoreboard and buffer model.
module tb_lenet_input_reader;

  localparam int AW = 10;
  localparam int N  = 1024;
  localparam int RW = 32;

  logic clk24      = 1'b0;
  logic rst_n      = 1'b0;
  logic enable     = 1'b0;
  logic data_ready = 1'b0;
  logic doing;
  logic frame_done;
  logic busy;

  int checks = 0;
  int errors = 0;

  lenet_input_reader_if #(.ADDR_W(AW)) bus ();

  lenet_input_reader #(.ADDR_W(AW)) dut (
    .clk24                (clk24),
    .rst_n                (rst_n),
    .i_enable             (enable),
    .i_lenet_data_ready   (data_ready),
    .o_lenet_doing_signal (doing),
    .o_frame_done         (frame_done),
    .o_busy               (busy),
    .bus                  (bus)
  );

  always #5 clk24 = ~clk24;

  // Buffer contents are buffer[a] = a[7:0], returned one cycle after the strobe.
  always @(posedge clk24) begin
    if (bus.rd_en) bus.rd_data <= bus.rd_addr[7:0];
  end

  logic [8:0] exp_q[$];
  bit         mon_on     = 1'b0;
  int         n_pix      = 0;
  int         rd_issued  = 0;
  int         rd_deliv   = 0;
  bit         stall_prev = 1'b0;
  bit         last_prev  = 1'b0;
  logic [8:0] stall_val;
  logic [8:0] m_got;
  logic [8:0] m_want;
  bit         got;
  int         lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit tb_pad(input int i);
    int r;
    int c;
    r = i / RW;
    c = i % RW;
    return (r < 2) || (r >= 30) || (c < 2) || (c >= 30);
  endfunction

  function automatic logic [8:0] exp_word(input int i);
    logic [8:0] w;
    w[7:0] = tb_pad(i) ? 8'h00 : 8'(i);
    w[8]   = (i == N - 1);
    return w;
  endfunction

  task automatic push_frame();
    for (int i = 0; i < N; i++) exp_q.push_back(exp_word(i));
    n_pix = 0;
  endtask

  task automatic pulse_ready();
    data_ready = 1'b1;
    @(posedge clk24);
    #1;
    data_ready = 1'b0;
  endtask

  task automatic wait_doing();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk24);
      #1;
      if (doing) break;
    end
    chk("capture_entry", doing, 1);
  endtask

  task automatic run_frame(input bit rnd, input int dis_at, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      @(posedge clk24);
      #1;
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
      bus.pix_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (dis_at >= 0 && n_pix >= dis_at) enable = 1'b0;
    end
    bus.pix_ready = 1'b1;
  endtask

  task automatic end_of_frame(input string tag, input bit seen);
    chk({tag, "_frame_done"}, seen, 1);
    chk({tag, "_pixel_count"}, n_pix, N);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  // Output monitor: scoreboard pops, stall stability, frame_done timing, read depth.
  always @(negedge clk24) begin
    if (mon_on) begin
      if (bus.rd_en) rd_issued++;
      if (stall_prev)
        chk("stall_hold", {bus.pix_valid, bus.pix_last, bus.pix_data}, {1'b1, stall_val});
      chk("frame_done_timing", frame_done, last_prev);
      last_prev = 1'b0;
      if (bus.pix_valid && bus.pix_ready) begin
        m_got = {bus.pix_last, bus.pix_data};
        if (exp_q.size() == 0) begin
          chk("pixel_overrun", exp_q.size(), 1);
        end else begin
          m_want = exp_q.pop_front();
          chk($sformatf("pix%0d", n_pix), m_got, m_want);
          if (!tb_pad(n_pix)) rd_deliv++;
        end
        n_pix++;
        last_prev = bus.pix_last;
      end
      chk("reads_outstanding_le2", (rd_issued - rd_deliv) <= 2, 1);
      stall_prev = bus.pix_valid && !bus.pix_ready;
      stall_val  = {bus.pix_last, bus.pix_data};
    end
  end

  initial begin
    bus.pix_ready = 1'b0;

    // reset and idle
    repeat (5) @(posedge clk24);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk24);
      chk("idle_outputs", {doing, bus.rd_en, bus.pix_valid, busy}, 4'b0000);
    end
    chk("idle_rd_addr", bus.rd_addr, 0);

    // full frame, ready held high
    mon_on        = 1'b1;
    bus.pix_ready = 1'b1;
    @(posedge clk24);
    #1 enable = 1'b1;
    wait_doing();
    push_frame();
    pulse_ready();
    chk("doing_drop", doing, 0);
    chk("busy_in_read", busy, 1);
    lat = 0;
    while (!bus.pix_valid && lat < 4) begin
      @(posedge clk24);
      #1;
      lat++;
    end
    chk("first_pix_latency_le3", lat <= 3, 1);
    run_frame(1'b0, -1, got);
    end_of_frame("full", got);
    @(posedge clk24);
    #1 chk("doing_rearm", doing, 1);

    // random backpressure
    push_frame();
    pulse_ready();
    run_frame(1'b1, -1, got);
    end_of_frame("bp", got);
    @(posedge clk24);
    #1 chk("doing_rearm_bp", doing, 1);

    // disable at pixel 500
    push_frame();
    pulse_ready();
    run_frame(1'b0, 500, got);
    end_of_frame("disable", got);
    @(posedge clk24);
    #1 chk("idle_after_disable", {doing, busy}, 2'b00);

    // spurious data_ready in IDLE, then early data_ready in CAPTURE cycle 1
    pulse_ready();
    repeat (3) @(posedge clk24);
    #1 chk("spurious_ignored", {doing, busy}, 2'b00);
    enable = 1'b1;
    @(posedge clk24);
    #1 chk("capture_cycle1", doing, 1);
    push_frame();
    pulse_ready();
    chk("early_ready_doing", doing, 0);
    chk("early_ready_busy", busy, 1);
    run_frame(1'b0, -1, got);
    end_of_frame("early", got);
    @(posedge clk24);
    #1 chk("doing_rearm_early", doing, 1);

    // async reset at pixel 300
    push_frame();
    pulse_ready();
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk24);
      #1;
      if (n_pix >= 300) break;
    end
    chk("reached_pixel_300", n_pix >= 300, 1);
    mon_on = 1'b0;
    rst_n  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk24);
      chk("reset_outputs",
          {doing, bus.rd_en, bus.pix_valid, bus.pix_last, frame_done, busy}, 6'b0);
      chk("reset_rd_addr", bus.rd_addr, 0);
    end
    exp_q.delete();
    n_pix      = 0;
    rd_issued  = 0;
    rd_deliv   = 0;
    stall_prev = 1'b0;
    last_prev  = 1'b0;
    @(posedge clk24);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk24);
      chk("post_reset_quiet",
          {doing, bus.pix_valid, bus.pix_last, frame_done, busy}, 5'b0);
    end

    // clean frame after reset
    mon_on = 1'b1;
    push_frame();
    @(posedge clk24);
    #1 enable = 1'b1;
    wait_doing();
    pulse_ready();
    run_frame(1'b0, -1, got);
    end_of_frame("after_reset", got);
    enable = 1'b0;
    repeat (3) @(posedge clk24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
